// File: rtl/tx_link_arbiter.sv
// tx_link_arbiter: holds Phy_Tx lane 0 idle until the Rx link is up, then
// round-robins four byte producers with bounded bursts into one stream.
// Ports: clk_f, reset (async, high), active (Rx link up), req[3:0],
//   data_req0..3 (bytes), gnt[3:0] (comb one-hot), data_out, valid_out and
//   link_up (all registered).
// Option: ARB_STRICT_PRIO_EN selects fixed priority (lowest index wins).
module tx_link_arbiter #(
  parameter int unsigned ACTIVE_CYCLES = 4,
  parameter int unsigned MAX_BURST     = 4,
  parameter logic [7:0]  IDLE_SYM      = 8'hBC
) (
  input  logic       clk_f,
  input  logic       reset,
  input  logic       active,
  input  logic [3:0] req,
  input  logic [7:0] data_req0,
  input  logic [7:0] data_req1,
  input  logic [7:0] data_req2,
  input  logic [7:0] data_req3,
  output logic [3:0] gnt,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       link_up
);

  typedef enum logic {S_TRAIN, S_ACTIVE} state_t;

  localparam logic [4:0] LP_ACT = 5'(ACTIVE_CYCLES);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_act_cnt;
  logic [4:0] w_cnt_inc;
  logic       w_arb_en;
  logic       w_win_valid;
  logic [1:0] w_win_idx;
  logic [7:0] w_sel;

`ifndef ARB_STRICT_PRIO_EN
  localparam logic [3:0] LP_MAX = 4'(MAX_BURST);
  logic [1:0] r_ptr;
  logic [1:0] r_owner;
  logic [3:0] r_burst;
  logic       w_cont;
`endif

  assign w_cnt_inc = {1'b0, r_act_cnt} + 5'd1;
  // Abort (active low while ACTIVE) wins over any grant that cycle.
  assign w_arb_en  = (r_state == S_ACTIVE) && active && !reset;

  // State register
  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) r_state <= S_TRAIN;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_TRAIN:  if (active && (w_cnt_inc >= LP_ACT)) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (!active) w_state_nxt = S_TRAIN;
    endcase
  end

  // Output logic: grant vector
  always_comb begin
    gnt = 4'b0000;
    if (w_arb_en && w_win_valid) gnt = 4'b0001 << w_win_idx;
  end

  // Consecutive-active counter, saturating at ACTIVE_CYCLES
  always_ff @(posedge clk_f or posedge reset) begin
    if (reset)
      r_act_cnt <= '0;
    else if (!active)
      r_act_cnt <= '0;
    else if (r_state == S_TRAIN && {1'b0, r_act_cnt} < LP_ACT)
      r_act_cnt <= w_cnt_inc[3:0];
  end

  // Winner selection
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = 2'd0;
`ifdef ARB_STRICT_PRIO_EN
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) begin
        w_win_valid = 1'b1;
        w_win_idx   = 2'(k);
      end
    end
`else
    w_cont = (r_burst != 4'd0) && req[r_owner] && (r_burst < LP_MAX);
    if (w_cont) begin
      w_win_valid = 1'b1;
      w_win_idx   = r_owner;
    end else begin
      // Descending scan so the entry nearest ptr is assigned last.
      for (int k = 3; k >= 0; k--) begin
        if (req[r_ptr + 2'(k)]) begin
          w_win_valid = 1'b1;
          w_win_idx   = r_ptr + 2'(k);
        end
      end
    end
`endif
  end

  always_comb begin
    unique case (w_win_idx)
      2'd0: w_sel = data_req0;
      2'd1: w_sel = data_req1;
      2'd2: w_sel = data_req2;
      2'd3: w_sel = data_req3;
    endcase
  end

  // Registered data path and burst bookkeeping
  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      data_out  <= IDLE_SYM;
      valid_out <= 1'b0;
      link_up   <= 1'b0;
`ifndef ARB_STRICT_PRIO_EN
      r_ptr     <= 2'd0;
      r_owner   <= 2'd0;
      r_burst   <= 4'd0;
`endif
    end else begin
      link_up <= (w_state_nxt == S_ACTIVE);
      if (w_arb_en && w_win_valid) begin
        data_out  <= w_sel;
        valid_out <= 1'b1;
`ifndef ARB_STRICT_PRIO_EN
        // ptr tracks owner+1 so the scan after a burst ends rotates on.
        r_ptr <= w_win_idx + 2'd1;
        if (w_cont) begin
          r_burst <= r_burst + 4'd1;
        end else begin
          r_owner <= w_win_idx;
          r_burst <= 4'd1;
        end
`endif
      end else begin
        data_out  <= IDLE_SYM;
        valid_out <= 1'b0;
`ifndef ARB_STRICT_PRIO_EN
        r_burst   <= 4'd0;
        if (r_state == S_ACTIVE && !active) r_ptr <= 2'd0;
`endif
      end
    end
  end

endmodule
